// File: rtl/bch_t10_next_mat_reader.sv
// Walks the BCH t=10 next-state coefficient ROM once per request and returns
// init XOR (XOR of the rows selected by the feedback vector).
module bch_t10_next_mat_reader #(
  parameter int unsigned NROWS = 20,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 160
) (
  input  logic             clk_1x,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NROWS-1:0] vec_in,
  input  logic [DW-1:0]    init_in,
  output logic             busy,
  output logic             rom_rd_en,
  output logic [AW-1:0]    rom_rdaddr,
  input  logic [DW-1:0]    rom_rd_q,
  output logic [DW-1:0]    result,
  output logic             result_valid
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_e;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NROWS - 1);

  state_e           state_q, state_d;
  logic [NROWS-1:0] vec_q, vec_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             rd_en_q, rd_en_d;
  logic             tag_v_q, tag_v_d;
  logic             tag_sel_q, tag_sel_d;
  logic             busy_q, busy_d;
  logic [DW-1:0]    result_q, result_d;
  logic             valid_q, valid_d;

  // State and registered outputs
  always_ff @(posedge clk_1x) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      tag_v_q   <= 1'b0;
      tag_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      tag_v_q   <= tag_v_d;
      tag_sel_q <= tag_sel_d;
      busy_q    <= busy_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  // Next state; the tag pair tracks the ROM's one-cycle read latency
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    tag_v_d   = 1'b0;
    tag_sel_d = 1'b0;
    result_d  = result_q;
    valid_d   = 1'b0;

    if (tag_v_q && tag_sel_q) begin
      acc_d = acc_q ^ rom_rd_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = vec_in;
          acc_d   = init_in;
          addr_d  = '0;
          rd_en_d = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        tag_v_d   = 1'b1;
        tag_sel_d = vec_q[addr_q];
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          addr_d  = addr_q + AW'(1);
          rd_en_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        result_d = acc_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy         = busy_q;
  assign rom_rd_en    = rd_en_q;
  assign rom_rdaddr   = addr_q;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_bch_t10_next_mat_reader.sv
// Directed bench for bch_t10_next_mat_reader with a stub ROM and a
// cycle-schedule reference model checked every cycle.
module tb_bch_t10_next_mat_reader;

  localparam int unsigned NROWS = 20;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 160;
  localparam int          LAT   = 23;

  logic             clk_1x = 1'b0;
  logic             rst_n;
  logic             start;
  logic [NROWS-1:0] vec_in;
  logic [DW-1:0]    init_in;
  logic             busy;
  logic             rom_rd_en;
  logic [AW-1:0]    rom_rdaddr;
  logic [DW-1:0]    rom_rd_q;
  logic [DW-1:0]    result;
  logic             result_valid;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bch_t10_next_mat_reader #(.NROWS(NROWS), .AW(AW), .DW(DW)) dut (
    .clk_1x(clk_1x), .rst_n(rst_n), .start(start), .vec_in(vec_in),
    .init_in(init_in), .busy(busy), .rom_rd_en(rom_rd_en),
    .rom_rdaddr(rom_rdaddr), .rom_rd_q(rom_rd_q), .result(result),
    .result_valid(result_valid)
  );

  always #5 clk_1x = ~clk_1x;

  // Stub ROM: row k holds k+1 in its low byte, registered read
  always @(posedge clk_1x) begin
    if (rom_rd_en) begin
      if (int'(rom_rdaddr) < NROWS)
        rom_rd_q <= {{(DW-8){1'b0}}, 8'(int'(rom_rdaddr) + 1)};
      else
        rom_rd_q <= '0;
    end
  end

  function automatic logic [DW-1:0] xor_rows(input logic [NROWS-1:0] v, input logic [DW-1:0] init);
    logic [DW-1:0] r;
    r = init;
    for (int k = 0; k < NROWS; k++)
      if (v[k]) r = r ^ DW'(k + 1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: ph = cycles since the accepting edge (0 = idle)
  int            ph = 0;
  logic [DW-1:0] pend = '0;
  logic [DW-1:0] m_res = '0;
  logic [AW-1:0] m_addr = '0;

  always @(posedge clk_1x) begin
    if (!rst_n) begin
      ph = 0; m_res = '0; m_addr = '0;
    end else begin
      if ((ph == 0 || ph == LAT) && start) begin
        ph = 1;
        pend = xor_rows(vec_in, init_in);
      end else if (ph >= 1 && ph < LAT) begin
        ph++;
      end else begin
        ph = 0;
      end
      if (ph == LAT) m_res = pend;
      if (ph >= 1 && ph <= NROWS) m_addr = AW'(ph - 1);
    end
  end

  always @(negedge clk_1x) begin
    if (chk_en) begin
      chk("busy", DW'(busy), DW'(ph >= 1 && ph < LAT));
      chk("rom_rd_en", DW'(rom_rd_en), DW'(ph >= 1 && ph <= NROWS));
      chk("rom_rdaddr", DW'(rom_rdaddr), DW'(m_addr));
      chk("result_valid", DW'(result_valid), DW'(ph == LAT));
      chk("result", result, m_res);
    end
  end

  // Issue one start (called right after a negedge) and wait for its result
  task automatic run_op(input logic [NROWS-1:0] v, input logic [DW-1:0] init,
                        output logic [DW-1:0] res, output int lat, output int rd_cnt);
    start = 1'b1; vec_in = v; init_in = init;
    lat = -1; rd_cnt = 0; res = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_1x);
      start = 1'b0;
      if (rom_rd_en) rd_cnt++;
      if (result_valid) begin
        lat = n; res = result;
        break;
      end
    end
  endtask

  logic [DW-1:0]    res, ones, rinit;
  logic [NROWS-1:0] rvec;
  int               lat, rd_cnt, nvalid;

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_in = '0; init_in = '0;
    ones = '1;
    repeat (3) @(posedge clk_1x);
    @(negedge clk_1x);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_busy", DW'(busy), '0);
    chk("reset_result", result, '0);
    chk("reset_addr", DW'(rom_rdaddr), '0);

    chk("pin_model_full", xor_rows(20'hFFFFF, '0), 160'h14);
    chk("pin_model_sparse", xor_rows(20'h00005, '0), 160'h2);
    chk("pin_model_top", xor_rows(20'h80000, '0), 160'h14);

    // Baseline
    run_op(20'h00000, '0, res, lat, rd_cnt);
    chk("base_lat", DW'(lat), DW'(LAT));
    chk("base_rdcnt", DW'(rd_cnt), DW'(20));
    chk("base_res", res, '0);
    chk("base_busy", DW'(busy), '0);

    // Full and sparse select
    run_op(20'hFFFFF, '0, res, lat, rd_cnt);
    chk("full_res", res, 160'h14);
    chk("full_lat", DW'(lat), DW'(LAT));
    run_op(20'h00005, '0, res, lat, rd_cnt);
    chk("sparse_res", res, 160'h2);
    run_op(20'h80000, '0, res, lat, rd_cnt);
    chk("top_res", res, 160'h14);

    // Init passthrough
    run_op(20'h00000, ones, res, lat, rd_cnt);
    chk("init_pass", res, ones);
    run_op(20'h00001, ones, res, lat, rd_cnt);
    chk("init_bit0", res, {ones[DW-1:1], 1'b0});

    // Start held high while busy
    start = 1'b1; vec_in = 20'h00003; init_in = '0;
    nvalid = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk_1x);
      if (n == 1) vec_in = 20'hFFFFF;
      if (n == 24) start = 1'b0;
      if (result_valid) begin
        nvalid++;
        if (nvalid == 1) begin
          chk("busy_first_n", DW'(n), DW'(23));
          chk("busy_first_res", result, 160'h3);
        end else if (nvalid == 2) begin
          chk("busy_second_n", DW'(n), DW'(46));
          chk("busy_second_res", result, 160'h14);
        end
      end
    end
    start = 1'b0;
    chk("busy_nvalid", DW'(nvalid), DW'(2));

    // Reset mid-operation
    start = 1'b1; vec_in = 20'hFFFFF; init_in = ones;
    nvalid = 0; rd_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_1x);
      start = 1'b0;
      if (n == 11) begin
        rst_n = 1'b1;
        chk("rst_busy", DW'(busy), '0);
        chk("rst_rd_en", DW'(rom_rd_en), '0);
        chk("rst_addr", DW'(rom_rdaddr), '0);
        chk("rst_result", result, '0);
      end
      if (n > 11 && rom_rd_en) rd_cnt++;
      if (result_valid) nvalid++;
      if (n == 10) rst_n = 1'b0;
    end
    chk("rst_nvalid", DW'(nvalid), '0);
    chk("rst_no_read", DW'(rd_cnt), '0);
    run_op(20'h00005, '0, res, lat, rd_cnt);
    chk("rst_after_res", res, 160'h2);
    chk("rst_after_lat", DW'(lat), DW'(LAT));

    // Back-to-back random operations
    for (int i = 0; i < 4; i++) begin
      rvec = NROWS'($urandom);
      rinit = {$urandom, $urandom, $urandom, $urandom, $urandom};
      run_op(rvec, rinit, res, lat, rd_cnt);
      chk("b2b_res", res, xor_rows(rvec, rinit));
      chk("b2b_lat", DW'(lat), DW'(LAT));
    end

    repeat (3) @(negedge clk_1x);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bch_t10_next_mat_reader.md
# bch_t10_next_mat_reader

Sequential reader and GF(2) matrix–vector engine for the DVB-S2 normal-frame t=10 BCH "next-state" coefficient ROM. On a start request it walks the ROM's 20 rows of 160 bits, one per cycle. It XOR-accumulates every row whose select bit is set in a 20-bit feedback vector, on top of an initial 160-bit value, and returns the 160-bit result with a one-cycle valid pulse. It sits between the BCH encoder control and the coefficient ROM, and is the ROM's only read master.

## Interface
- NROWS, 20, number of ROM rows walked per operation (addresses 0..NROWS-1)
- AW, 5, ROM address width
- DW, 160, ROM word / result width
- clk_1x  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- vec_in  in  NROWS  row-select vector; bit k selects row k; latched on accepted start
- init_in  in  DW  initial accumulator value; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until result_valid
- rom_rd_en  out  1  ROM read enable
- rom_rdaddr  out  AW  ROM read address
- rom_rd_q  in  DW  ROM data; registered in the ROM, valid one cycle after rom_rd_en
- result  out  DW  init_in XOR (XOR of selected rows); holds until the next result
- result_valid  out  1  one-cycle pulse when result is updated

## Operation
- The FSM has four states: IDLE, READ, DRAIN, and OUT.
- IDLE:
  - On start=1, latch vec_in into vec_r and init_in into acc, and clear addr.
  - Go to READ.
  - Otherwise remain in IDLE.
- READ:
  - Drive rom_rd_en=1 and rom_rdaddr=addr, then increment addr.
  - Register a pipeline tag pair (tag_v=1, tag_sel=vec_r[addr]) alongside the read.
  - When addr==NROWS-1, go to DRAIN.
- Accumulate rule, applied every cycle:
  - If tag_v=1 and tag_sel=1, then acc <= acc ^ rom_rd_q.
  - If tag_v=1 and tag_sel=0, acc is unchanged.
  - Rows are combined by XOR only; there is no carry and no width growth.
- DRAIN:
  - rom_rd_en=0 and tag_v clears.
  - The last row's accumulate occurs in this cycle.
  - Next state is OUT.
- OUT:
  - result <= acc and result_valid=1 for this single cycle.
  - Return to IDLE.
- Boundary conditions:
  - start while busy (READ, DRAIN, OUT) is ignored. It is not queued and vec_r/init_r are not disturbed.
  - Addresses >= NROWS are never issued.
  - rom_rdaddr holds its last value (NROWS-1) whenever rom_rd_en=0.
  - vec_in=0 gives result=init_in. The ROM is still walked all 20 rows so latency stays fixed.
  - rst_n=0 at any point:
    - All state is cleared and the FSM returns to IDLE.
    - A partial accumulation is discarded and no result_valid is generated.
    - result is cleared to 0.

## Timing
- Reset values: busy=0, rom_rd_en=0, rom_rdaddr=0, result=0, result_valid=0, FSM=IDLE, acc=0, addr=0, tag_v=0.
- Cycle sequence for a start sampled high in IDLE at edge of cycle T:
  - READ occupies cycles T+1..T+20, with rom_rd_en=1 and rom_rdaddr=0..19 in order.
  - rom_rd_q for row k is consumed in cycle T+2+k. The last row is consumed in T+21, during DRAIN.
  - OUT occurs in cycle T+22.
  - result and result_valid are registered, so both are visible in cycle T+23.
- busy is high in cycles T+1..T+22 and low again in T+23. A new start is accepted in T+23 at the earliest (back-to-back).
- Fixed latency: 23 cycles from the start edge to result_valid. Throughput: one operation per 23 cycles.
- There is no combinational path from any input to any output.

## Test plan
The bench uses a stub ROM with a 1-cycle registered read: row k = {152'b0, 8'(k+1)}, and any other address returns 0.

- **Baseline:** vec_in=20'h00000, init_in=0, one start pulse.
  - rom_rd_en is high for exactly 20 consecutive cycles with addresses 0..19.
  - result_valid pulses once at T+23 with result=0.
  - busy is low again at T+23.
- **Full and sparse select:**
  - vec_in=20'hFFFFF → result low byte 8'h14 (XOR of 1..20), upper bits 0.
  - vec_in=20'h00005 → result=160'h2.
  - vec_in=20'h80000 → result=160'h14.
- **Init passthrough:** init_in=all ones, vec_in=0 → result=all ones. Then init_in=all ones, vec_in=20'h00001 → result=all ones with bit0 cleared.
- **Start while busy:**
  - Start A (vec=20'h00003), then assert start continuously with vec=20'hFFFFF.
  - The first result is 160'h3 at T+23.
  - The second start is accepted at T+23 and its result is 160'h14 at T+46.
  - No other result_valid pulses occur.
- **Reset mid-operation:** pull rst_n low at T+10 for 1 cycle.
  - All outputs become 0 on the next edge.
  - No result_valid occurs, and rom_rd_en stays 0 until the next start.
  - A subsequent start with vec=20'h00005 returns 160'h2 after 23 cycles.
- **Back-to-back:** 4 starts issued at the earliest accept cycles with random vec_in/init_in. Results match the reference-model XOR, with results spaced exactly 23 cycles apart.
